// File: rtl/gsim_residual.sv
// Residual checker for the banded GSIM system: r = M*x - b over one 16-element frame.
// Loads b and x from the solver taps, then walks 7 taps per row and tracks the peak |r|.
module gsim_residual (
   input  logic        clk,
   input  logic        reset,
   input  logic        in_en,
   input  logic [15:0] b_in,
   input  logic        out_valid,
   input  logic [31:0] x_out,
   output logic        r_valid,
   output logic [31:0] r_out,
   output logic        done,
   output logic [31:0] max_abs
);

   typedef enum logic [1:0] {IDLE, LOAD, CALC, DONE} state_t;

   localparam logic signed [47:0] SAT_MAX = 48'sh0000_7FFF_FFFF;
   localparam logic signed [47:0] SAT_MIN = 48'shFFFF_8000_0000;

   state_t             state;
   logic        [4:0]  b_cnt;
   logic        [4:0]  x_cnt;
   logic        [3:0]  row;
   logic        [2:0]  tap;
   logic signed [47:0] acc;
   logic        [31:0] run_max;

   logic        [15:0] b_mem [16];
   logic        [31:0] x_mem [16];

   logic               loading;
   logic               store_b;
   logic               store_x;
   logic signed [5:0]  j_pos;
   logic               in_range;
   logic signed [5:0]  coef;
   logic        [31:0] x_sel;
   logic signed [47:0] coef_ext;
   logic signed [47:0] x_ext;
   logic signed [47:0] term;
   logic signed [47:0] b_ext;
   logic signed [47:0] res_full;
   logic        [31:0] res_sat;
   logic        [31:0] res_abs;
   logic        [31:0] frame_max;

   // Strobes are only captured while loading and only until 16 of each kind arrived.
   always_comb begin
      loading = (state == IDLE) || (state == LOAD);
      store_b = loading && in_en && !b_cnt[4];
      store_x = loading && out_valid && !x_cnt[4];
   end

   // Tap t of row i reads column j = i - 3 + t; the coefficient depends only on |t - 3|.
   always_comb begin
      j_pos    = $signed({2'b00, row}) + $signed({3'b000, tap}) - 6'sd3;
      in_range = !j_pos[5] && !j_pos[4];
      case (tap)
         3'd3:       coef = 6'sd20;
         3'd2, 3'd4: coef = -6'sd13;
         3'd1, 3'd5: coef = 6'sd6;
         default:    coef = -6'sd1;
      endcase
      x_sel    = in_range ? x_mem[j_pos[3:0]] : 32'h0;
      coef_ext = {{42{coef[5]}}, coef};
      x_ext    = {{16{x_sel[31]}}, x_sel};
      term     = coef_ext * x_ext;
      b_ext    = {{16{b_mem[row][15]}}, b_mem[row], 16'h0000};
      res_full = acc + term - b_ext;
   end

   // Clamp to Q16.16 and fold the most negative value onto the largest magnitude.
   always_comb begin
      if (res_full > SAT_MAX) begin
         res_sat = 32'h7FFF_FFFF;
      end else if (res_full < SAT_MIN) begin
         res_sat = 32'h8000_0000;
      end else begin
         res_sat = res_full[31:0];
      end
      if (res_sat == 32'h8000_0000) begin
         res_abs = 32'h7FFF_FFFF;
      end else if (res_sat[31]) begin
         res_abs = -res_sat;
      end else begin
         res_abs = res_sat;
      end
      frame_max = (res_abs > run_max) ? res_abs : run_max;
   end

   // Element storage is not reset; the counters alone define what is valid.
   always_ff @(posedge clk) begin
      if (store_b) begin
         b_mem[b_cnt[3:0]] <= b_in;
      end
      if (store_x) begin
         x_mem[x_cnt[3:0]] <= x_out;
      end
   end

   // Frame sequencer: gather both vectors, sweep 16 rows x 7 taps, publish the peak.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         b_cnt   <= 5'd0;
         x_cnt   <= 5'd0;
         row     <= 4'd0;
         tap     <= 3'd0;
         acc     <= 48'sd0;
         run_max <= 32'h0;
         r_valid <= 1'b0;
         r_out   <= 32'h0;
         done    <= 1'b0;
         max_abs <= 32'h0;
      end else begin
         r_valid <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (store_b) begin
                  b_cnt <= b_cnt + 5'd1;
               end
               if (store_x) begin
                  x_cnt <= x_cnt + 5'd1;
               end
               if (in_en || out_valid) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               if (store_b) begin
                  b_cnt <= b_cnt + 5'd1;
               end
               if (store_x) begin
                  x_cnt <= x_cnt + 5'd1;
               end
               if (b_cnt[4] && x_cnt[4]) begin
                  state <= CALC;
                  row   <= 4'd0;
                  tap   <= 3'd0;
                  acc   <= 48'sd0;
               end
            end
            CALC: begin
               if (tap == 3'd6) begin
                  r_out   <= res_sat;
                  r_valid <= 1'b1;
                  run_max <= frame_max;
                  acc     <= 48'sd0;
                  tap     <= 3'd0;
                  if (row == 4'd15) begin
                     state   <= DONE;
                     done    <= 1'b1;
                     max_abs <= frame_max;
                  end else begin
                     row <= row + 4'd1;
                  end
               end else begin
                  acc <= acc + term;
                  tap <= tap + 3'd1;
               end
            end
            DONE: begin
               state   <= IDLE;
               b_cnt   <= 5'd0;
               x_cnt   <= 5'd0;
               run_max <= 32'h0;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_gsim_residual.sv
// Testbench for gsim_residual: table-driven frames plus reset-abort and overflow sequences,
// with a queue scoreboard of expected residuals checked as the DUT strobes them out.
module tb_gsim_residual;

   typedef logic [15:0] barr_t [16];
   typedef logic [31:0] xarr_t [16];

   typedef struct {
      logic [31:0] x0;
      logic [15:0] b0;
      logic [31:0] r0;
      logic [31:0] r1;
      logic [31:0] r2;
      logic [31:0] r3;
      logic [31:0] mx;
      int          mode;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_en = 1'b0;
   logic [15:0] b_in = 16'h0;
   logic        out_valid = 1'b0;
   logic [31:0] x_out = 32'h0;
   logic        r_valid;
   logic [31:0] r_out;
   logic        done;
   logic [31:0] max_abs;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int last_drive_cyc = 0;
   int last_rv_cyc = 0;
   int rows_seen = 0;
   int rv_count = 0;
   int done_count = 0;
   logic prev_done = 1'b0;
   logic [31:0] last_max = 32'h0;

   logic [31:0] exp_q [$];
   logic [31:0] max_q [$];

   gsim_residual dut (
      .clk       (clk),
      .reset     (reset),
      .in_en     (in_en),
      .b_in      (b_in),
      .out_valid (out_valid),
      .x_out     (x_out),
      .r_valid   (r_valid),
      .r_out     (r_out),
      .done      (done),
      .max_abs   (max_abs)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   // Independent reference: direct banded matrix-vector product in 64-bit arithmetic.
   function automatic void model(input barr_t bv, input xarr_t xv, output xarr_t r, output logic [31:0] mx);
      longint s;
      int d;
      int coef;
      logic [31:0] a;
      mx = 32'h0;
      for (int i = 0; i < 16; i++) begin
         s = -(longint'($signed(bv[i])) * 65536);
         for (int j = 0; j < 16; j++) begin
            d = (i > j) ? i - j : j - i;
            case (d)
               0: coef = 20;
               1: coef = -13;
               2: coef = 6;
               3: coef = -1;
               default: coef = 0;
            endcase
            s += longint'(coef) * longint'($signed(xv[j]));
         end
         if (s > 64'sd2147483647) r[i] = 32'h7FFF_FFFF;
         else if (s < -64'sd2147483648) r[i] = 32'h8000_0000;
         else r[i] = s[31:0];
         if (r[i] == 32'h8000_0000) a = 32'h7FFF_FFFF;
         else if (r[i][31]) a = -r[i];
         else a = r[i];
         if (a > mx) mx = a;
      end
   endfunction

   // Scoreboard side: every strobe is popped against the queue and timed.
   always @(negedge clk) begin
      if (reset) begin
         rows_seen = 0;
         prev_done = 1'b0;
      end else begin
         if (r_valid) begin
            rv_count++;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_r_valid: got r_out=%h, required no strobe", r_out);
            end else begin
               checkOutput($sformatf("r_out_row%0d", rows_seen), r_out, exp_q.pop_front());
            end
            if (rows_seen == 0) checkOutput("row0_latency", cyc, last_drive_cyc + 9);
            else checkOutput("row_spacing", cyc - last_rv_cyc, 32'd7);
            last_rv_cyc = cyc;
            rows_seen++;
         end
         if (done) begin
            done_count++;
            if (max_q.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL unexpected_done: got max_abs=%h, required no done", max_abs);
            end else begin
               checkOutput("max_abs", max_abs, max_q.pop_front());
            end
            checkOutput("rows_before_done", rows_seen, 32'd16);
            checkOutput("done_width", {31'b0, prev_done}, 32'd0);
            rows_seen = 0;
         end
         prev_done = done;
      end
   end

   // mode 0: b and x together, 1: all x then all b, 2: random gaps, 3: all b, a 17th b, then all x.
   task automatic applyStimulus(input barr_t bv, input xarr_t xv, input int mode);
      int bi = 0;
      int xi = 0;
      bit extra = 1'b0;
      bit db;
      bit dx;
      checkOutput("max_abs_hold", max_abs, last_max);
      while (bi < 16 || xi < 16) begin
         @(posedge clk);
         #1;
         case (mode)
            0: begin db = bi < 16; dx = xi < 16; end
            1: begin dx = xi < 16; db = (xi >= 16) && (bi < 16); end
            2: begin
               db = (bi < 16) && ($urandom_range(0, 1) == 1);
               dx = (xi < 16) && ($urandom_range(0, 1) == 1);
            end
            default: begin db = bi < 16; dx = (bi >= 16) && extra && (xi < 16); end
         endcase
         in_en     = db;
         out_valid = dx;
         b_in      = db ? bv[bi] : 16'h0;
         x_out     = dx ? xv[xi] : 32'h0;
         if (mode == 3 && bi >= 16 && !extra) begin
            in_en = 1'b1;
            b_in  = 16'h7FFF;
            extra = 1'b1;
         end
         if (in_en || out_valid) last_drive_cyc = cyc;
         if (db) bi++;
         if (dx) xi++;
      end
      @(posedge clk);
      #1;
      in_en     = 1'b0;
      out_valid = 1'b0;
   endtask

   task automatic waitDone(input int bound);
      int start;
      int n;
      start = done_count;
      n = 0;
      while (done_count == start && n < bound) begin
         @(posedge clk);
         n++;
      end
      if (done_count == start) begin
         checks++;
         errors++;
         $display("[TB] FAIL done_timeout: got no done after %0d cycles, required done", bound);
      end
      repeat (2) @(posedge clk);
   endtask

   task automatic pushVec(input vec_t v, input int rows, input bit with_max);
      logic [31:0] rv;
      for (int i = 0; i < rows; i++) begin
         case (i)
            0: rv = v.r0;
            1: rv = v.r1;
            2: rv = v.r2;
            3: rv = v.r3;
            default: rv = 32'h0;
         endcase
         exp_q.push_back(rv);
      end
      if (with_max) max_q.push_back(v.mx);
   endtask

   task automatic buildVec(input vec_t v, output barr_t bv, output xarr_t xv);
      for (int i = 0; i < 16; i++) begin
         bv[i] = 16'h0;
         xv[i] = 32'h0;
      end
      bv[0] = v.b0;
      xv[0] = v.x0;
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_r_valid"}, {31'b0, r_valid}, 32'd0);
      checkOutput({tag, "_done"}, {31'b0, done}, 32'd0);
      checkOutput({tag, "_r_out"}, r_out, 32'h0);
      checkOutput({tag, "_max_abs"}, max_abs, 32'h0);
   endtask

   initial begin
      vec_t vecs [5];
      vec_t unit_v;
      barr_t bv;
      xarr_t xv;
      xarr_t rr;
      logic [31:0] mx;
      int base;
      int n;

      vecs[0] = '{x0: 32'h0000_0000, b0: 16'h0000, r0: 32'h0000_0000, r1: 32'h0,
                  r2: 32'h0, r3: 32'h0, mx: 32'h0000_0000, mode: 0};
      vecs[1] = '{x0: 32'h0001_0000, b0: 16'h0000, r0: 32'h0014_0000, r1: 32'hFFF3_0000,
                  r2: 32'h0006_0000, r3: 32'hFFFF_0000, mx: 32'h0014_0000, mode: 0};
      vecs[2] = '{x0: 32'h0000_0000, b0: 16'h0001, r0: 32'hFFFF_0000, r1: 32'h0,
                  r2: 32'h0, r3: 32'h0, mx: 32'h0001_0000, mode: 0};
      vecs[3] = '{x0: 32'h7FFF_FFFF, b0: 16'h0000, r0: 32'h7FFF_FFFF, r1: 32'h8000_0000,
                  r2: 32'h7FFF_FFFF, r3: 32'h8000_0001, mx: 32'h7FFF_FFFF, mode: 0};
      vecs[4] = vecs[3];
      vecs[4].mode = 1;
      unit_v = vecs[1];

      repeat (3) @(posedge clk);
      #1;
      checkResetOutputs("reset");
      reset = 1'b0;
      repeat (2) @(posedge clk);

      for (int k = 0; k < 5; k++) begin
         buildVec(vecs[k], bv, xv);
         pushVec(vecs[k], 16, 1'b1);
         applyStimulus(bv, xv, vecs[k].mode);
         waitDone(300);
         last_max = vecs[k].mx;
      end

      // Abort in the middle of row 5: rows 0-4 are expected, nothing after.
      buildVec(unit_v, bv, xv);
      pushVec(unit_v, 5, 1'b0);
      base = rv_count;
      applyStimulus(bv, xv, 0);
      n = 0;
      while (rv_count < base + 5 && n < 200) begin
         @(posedge clk);
         n++;
      end
      checkOutput("abort_rows_seen", rv_count - base, 32'd5);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      checkResetOutputs("abort");
      checkOutput("abort_queue_empty", exp_q.size(), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      last_max = 32'h0;
      repeat (150) @(posedge clk);
      #1;
      checkResetOutputs("post_abort");

      // Clean unit-x frame after the abort, with a 17th b strobe that must be dropped.
      pushVec(unit_v, 16, 1'b1);
      applyStimulus(bv, xv, 3);
      waitDone(300);
      last_max = unit_v.mx;

      // Random frame with random strobe gaps, checked against the reference model.
      for (int i = 0; i < 16; i++) begin
         bv[i] = 16'($urandom_range(0, 65535));
         xv[i] = ($urandom() & 32'h001F_FFFF) - 32'h0010_0000;
      end
      model(bv, xv, rr, mx);
      for (int i = 0; i < 16; i++) exp_q.push_back(rr[i]);
      max_q.push_back(mx);
      applyStimulus(bv, xv, 2);
      waitDone(400);
      last_max = mx;
      repeat (4) @(posedge clk);
      #1;
      checkOutput("final_max_abs_hold", max_abs, last_max);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/gsim_residual.md
GSIM_RESIDUAL -- requirements
Module: gsim_residual

Interface
REQ-001 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 Port reset, input, 1: asynchronous, active-high reset.
REQ-003 Port in_en, input, 1: b-element strobe, tapped from the GSIM solver input.
REQ-004 Port b_in, input, 16: signed integer b element; valid when in_en=1.
REQ-005 Port out_valid, input, 1: x-element strobe from the GSIM solver output.
REQ-006 Port x_out, input, 32: signed Q16.16 x element; valid when out_valid=1.
REQ-007 Port r_valid, output, 1: one-cycle strobe qualifying r_out.
REQ-008 Port r_out, output, 32: signed Q16.16 residual of the current row.
REQ-009 Port done, output, 1: one-cycle pulse at end of frame.
REQ-010 Port max_abs, output, 32: unsigned Q16.16 maximum |r| of the last completed frame.

Function
REQ-011 Block SHALL compute r_i = sum_j M[i][j]*x_j - b_i for i=0..15, where M[i][j] = 20 if |i-j|=0; -13 if 1; 6 if 2; -1 if 3; 0 otherwise.
REQ-012 FSM SHALL have states IDLE, LOAD, CALC and DONE; reset enters IDLE.
REQ-013 IDLE->LOAD on first in_en or out_valid; that element is stored.
REQ-014 In LOAD and IDLE, b elements SHALL be stored in arrival order into b[0..15]; x elements SHALL be stored into x[0..15]; the two counters are independent and may interleave.
REQ-015 Strobes beyond the 16th of each kind, and all strobes in CALC/DONE, SHALL be ignored.
REQ-016 LOAD->CALC on the edge after both counters reach 16.
REQ-017 In CALC, one tap per cycle: row i, tap t=0..6, with j=i-3+t; out-of-range j contributes 0 but still consumes its cycle.
REQ-018 Each row therefore SHALL take 7 cycles, and 16 rows SHALL take 112 CALC cycles.
REQ-019 The accumulator SHALL be at least 42-bit signed; coefficient products use full width with no intermediate truncation.
REQ-020 At tap 6, the residual SHALL be computed as acc + term - (sign-extended b_i << 16).
REQ-021 The residual SHALL be saturated to the 32-bit signed range and registered to r_out, with r_valid=1 in the following cycle; the accumulator then clears.
REQ-022 r_out SHALL hold its value between strobes.
REQ-023 Row 0 residual SHALL appear in the cycle after the 7th CALC edge; subsequent rows SHALL appear every 7 cycles.
REQ-024 A running maximum of |r| SHALL be kept over saturated residuals; |0x80000000| SHALL count as 0x7FFFFFFF.
REQ-025 After row 15, CALC->DONE: done=1 for one cycle, and max_abs SHALL update to the frame maximum in that same cycle.
REQ-026 DONE->IDLE next cycle; both counters clear and the running maximum clears.
REQ-027 max_abs SHALL hold its value until the next frame's DONE.
REQ-028 A strobe arriving in the DONE cycle SHALL be ignored.

Reset
REQ-029 On reset assertion, r_valid, done, r_out and max_abs SHALL go to 0 immediately.
REQ-030 On reset, the state SHALL go to IDLE and the counters and accumulator SHALL clear.
REQ-031 Stored b/x arrays need not be cleared by reset.
REQ-032 Reset asserted mid-LOAD or mid-CALC SHALL abort the frame with no r_valid or done emitted.
REQ-033 The first strobe after reset release SHALL be treated as element 0.

Verification
REQ-034 Zero frame: b=0 and x=0 for all 16 elements -> 16 r_valid strobes 7 cycles apart, each r_out=0x00000000; done=1; max_abs=0.
REQ-035 Unit x: b=0, x0=0x00010000, other x=0 -> r_out sequence 0x00140000, 0xFFF30000, 0x00060000, 0xFFFF0000, then 12 zeros; max_abs=0x00140000.
REQ-036 b only: b0=0x0001, all x=0 -> r0=0xFFFF0000, rest 0; max_abs=0x00010000.
REQ-037 Saturation and ordering: x0=0x7FFFFFFF, others 0, b=0 -> r0=0x7FFFFFFF, r1=0x80000000, max_abs=0x7FFFFFFF; also all 16 x before any b gives the same results as interleaved arrival.
REQ-038 Reset and overflow: reset pulsed during CALC row 5 -> no further r_valid/done and outputs read 0; a following clean unit-x frame reproduces REQ-035 exactly; a 17th in_en is ignored.
